// File: rtl/pc_trace_buf_if.sv
// Read port of the PC trace buffer: valid/ready handshake plus {cycle, pc} head entry.
// master = the trace buffer (producer); slave = the consumer draining it.
interface pc_trace_buf_if #(
  parameter int PC_W  = 32,
  parameter int CYC_W = 16
);
  logic                  rd_valid;
  logic                  rd_ready;
  logic [CYC_W+PC_W-1:0] rd_data;

  modport master (output rd_valid, output rd_data, input  rd_ready);
  modport slave  (input  rd_valid, input  rd_data, output rd_ready);
endinterface

// File: rtl/pc_trace_buf.sv
// PC trace buffer: timestamps each PC-update strobe into a FWFT FIFO; a trigger PC freezes capture.
// Optional feature: define PC_TRACE_FILTER_EN to drop captures that repeat the last captured PC.
module pc_trace_buf #(
  parameter int PC_W  = 32,
  parameter int CYC_W = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PC_W-1:0]          pc_in,
  input  logic                     pc_valid,
  input  logic                     arm,
  input  logic                     disarm,
  input  logic                     trig_en,
  input  logic [PC_W-1:0]          trig_pc,
  input  logic                     clr_ovf,
  pc_trace_buf_if.master           rd,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     frozen
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int ENT_W = CYC_W + PC_W;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FROZEN = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [CYC_W-1:0] cyc;
  logic [ENT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [ENT_W-1:0] hold_q;

  logic filt_ok;
  logic cap_req;
  logic full;
  logic pop;
  logic cap_acc;
  logic cap_drop;
  logic trig_hit;

  // Repeat filter: the "none yet" flag guarantees the first capture after reset.
`ifdef PC_TRACE_FILTER_EN
  logic [PC_W-1:0] last_pc;
  logic            last_none;

  assign filt_ok = last_none || (pc_in != last_pc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_pc   <= '0;
      last_none <= 1'b1;
    end else if (cap_acc) begin
      last_pc   <= pc_in;
      last_none <= 1'b0;
    end
  end
`else
  assign filt_ok = 1'b1;
`endif

  assign full     = (count == FULL_CNT);
  assign pop      = rd.rd_valid && rd.rd_ready;
  assign cap_req  = (state == ST_RUN) && pc_valid && filt_ok;
  // A same-cycle pop frees the slot the write lands in, so full only blocks without a pop.
  assign cap_acc  = cap_req && (!full || pop);
  assign cap_drop = cap_req && full && !pop;
  assign trig_hit = cap_acc && trig_en && (pc_in == trig_pc);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (arm && !disarm) state_nxt = ST_RUN;
      ST_RUN:    if (disarm)         state_nxt = ST_IDLE;
                 else if (trig_hit)  state_nxt = ST_FROZEN;
      ST_FROZEN: if (disarm)         state_nxt = ST_IDLE;
                 else if (arm)       state_nxt = ST_RUN;
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cyc   <= '0;
    end else begin
      state <= state_nxt;
      cyc   <= cyc + CYC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (cap_acc) mem[wr_ptr] <= {cyc, pc_in};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      hold_q   <= '0;
      overflow <= 1'b0;
    end else begin
      if (cap_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        hold_q <= mem[rd_ptr];
      end
      case ({cap_acc, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (cap_drop)     overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // Once drained, the output keeps showing the last entry popped.
  assign rd.rd_valid = (count != '0);
  assign rd.rd_data  = rd.rd_valid ? mem[rd_ptr] : hold_q;
  assign frozen      = (state == ST_FROZEN);

endmodule
